vx_writeback_arb: RTL and testbench
===================================

// Module: vx_writeback_arb
// PURPOSE
// Producer side of the writeback interface consumed by the issue stage (scoreboard + GPR).
// Collects commit streams from ALU/LSU/CSR/FPU/GPU and arbitrates them round-robin onto one
// registered writeback port. Multi-beat responses stay atomic until eop. Also reports retired thread-instructions.
// PARAMETERS
// NUM_REQS     5   number of execute-unit commit inputs (index 0 = ALU ... 4 = GPU)
// NUM_THREADS  4   threads per warp (tmask width)
// NW_BITS      2   warp id width
// NR_BITS      5   register index width
// PC_W         32  PC width
// DATA_W       32  per-thread data width
// UUID_W       44  instruction uuid width
// PORTS
// clk            in   1                       clock
// reset          in   1                       synchronous, active-high
// in_valid       in   NUM_REQS                commit request per unit
// in_ready       out  NUM_REQS                request consumed this cycle
// in_uuid        in   NUM_REQS*UUID_W         per-unit uuid
// in_wid         in   NUM_REQS*NW_BITS        per-unit warp id
// in_tmask       in   NUM_REQS*NUM_THREADS    per-unit thread mask
// in_PC          in   NUM_REQS*PC_W           per-unit PC
// in_wb          in   NUM_REQS                1 = writes rd
// in_rd          in   NUM_REQS*NR_BITS        per-unit destination register
// in_data        in   NUM_REQS*NUM_THREADS*DATA_W  per-unit result data
// in_eop         in   NUM_REQS                last beat of instruction
// wb_valid       out  1                       writeback beat valid (no backpressure)
// wb_uuid/wb_wid/wb_tmask/wb_PC/wb_rd/wb_data/wb_eop  out  field widths  registered winner fields
// retire_valid   out  1                       retire_cnt valid this cycle
// retire_cnt     out  $clog2(NUM_REQS*NUM_THREADS+1)  sum of popcount(tmask) over eop beats fired last cycle
// BEHAVIOUR
// - Reset: wb_valid=0, all wb_* fields 0, retire_valid=0, retire_cnt=0, rr pointer=0, lock cleared.
// - fire[i] = in_valid[i] & in_ready[i]. Writeback port never stalls.
// - in_wb[i]=0: in_ready[i]=1 unconditionally (drains in parallel, no port use, no effect on rr/lock).
// - in_wb[i]=1: in_ready[i]=1 only for grant index; at most one wb grant per cycle.
// - Arbiter states: IDLE -> grant = first valid wb requestor at or after rr pointer (wrapping
//   NUM_REQS-1 -> 0); on fire, rr <= grant+1 mod NUM_REQS; if in_eop=0 go LOCKED(idx=grant).
// - LOCKED: only idx may be granted; others held (ready=0) even if idx invalid this cycle;
//   fire with eop=1 -> IDLE, rr <= idx+1. rr unchanged while locked.
// - Output latency 1 cycle: wb_* <= granted fields when a wb fire occurs; else wb_valid<=0, fields hold.
// - retire: retire_cnt <= sum popcount(in_tmask[i]) over fired i with in_eop[i]=1 (wb and non-wb);
//   retire_valid <= (retire_cnt next != 0). Max value NUM_REQS*NUM_THREADS, no overflow.
// - No valid inputs: no grant, rr/lock unchanged.
// - Reset mid-packet: lock dropped, wb_valid=0 next cycle; upstream resets in same cycle.
// - in_ready must not depend on wb_* (no combinational loop); it depends on in_valid/in_wb/state only.
// CONFIGURATION
// WB_ARB_PERF_EN defined: adds outputs perf_wb_stalls [43:0] and perf_wb_beats [43:0]. Reset 0;
//   stalls +1 each cycle any wb requestor valid && !in_ready; beats +1 per wb fire; wrap at 2^44.
// WB_ARB_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
// 1 reset 3 cycles, all valid=0 -> wb_valid=0, retire_valid=0, in_ready = ~in_wb (=5'b11111 with in_wb=0).
// 2 ALU(0) and LSU(1) wb valid every cycle, eop=1 -> wb_valid each cycle from cycle 2, alternating 0,1,0,1.
// 3 LSU 3-beat packet (eop on beat 3) with ALU valid throughout -> 3 consecutive LSU beats, then ALU.
// 4 CSR wb=0 tmask=4'b1011 eop=1 and ALU wb=1 tmask=4'b1111 same cycle -> both ready; retire_cnt=7 next cycle.
// 5 LSU locked, valid drops 2 cycles while FPU valid -> FPU ready=0 until LSU eop beat fires.
// 6 WB_ARB_PERF_EN: scenario 2 for 10 cycles -> perf_wb_beats=10, perf_wb_stalls=10; assert reset mid-lock -> IDLE.

Source files
------------

// File: rtl/vx_writeback_arb_if.sv
// Writeback arbiter bus: per-unit commit streams in, one registered writeback
// port plus the retire count out. The arbiter takes the slave side; the
// execute units and the issue stage together form the master side.
interface vx_writeback_arb_if #(
  parameter int NUM_REQS    = 5,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 5,
  parameter int PC_W        = 32,
  parameter int DATA_W      = 32,
  parameter int UUID_W      = 44
);
  localparam int RCNT_W = $clog2(NUM_REQS * NUM_THREADS + 1);

  // Commit side, flattened per unit (unit 0 in the low slice)
  logic [NUM_REQS-1:0]                    in_valid;
  logic [NUM_REQS-1:0]                    in_ready;
  logic [NUM_REQS*UUID_W-1:0]             in_uuid;
  logic [NUM_REQS*NW_BITS-1:0]            in_wid;
  logic [NUM_REQS*NUM_THREADS-1:0]        in_tmask;
  logic [NUM_REQS*PC_W-1:0]               in_PC;
  logic [NUM_REQS-1:0]                    in_wb;
  logic [NUM_REQS*NR_BITS-1:0]            in_rd;
  logic [NUM_REQS*NUM_THREADS*DATA_W-1:0] in_data;
  logic [NUM_REQS-1:0]                    in_eop;

  // Writeback side (no backpressure)
  logic                                   wb_valid;
  logic [UUID_W-1:0]                      wb_uuid;
  logic [NW_BITS-1:0]                     wb_wid;
  logic [NUM_THREADS-1:0]                 wb_tmask;
  logic [PC_W-1:0]                        wb_PC;
  logic [NR_BITS-1:0]                     wb_rd;
  logic [NUM_THREADS*DATA_W-1:0]          wb_data;
  logic                                   wb_eop;

  // Retired thread-instruction count
  logic                                   retire_valid;
  logic [RCNT_W-1:0]                      retire_cnt;

  modport master (
    output in_valid, in_uuid, in_wid, in_tmask, in_PC, in_wb, in_rd, in_data, in_eop,
    input  in_ready,
    input  wb_valid, wb_uuid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, wb_eop,
    input  retire_valid, retire_cnt
  );

  modport slave (
    input  in_valid, in_uuid, in_wid, in_tmask, in_PC, in_wb, in_rd, in_data, in_eop,
    output in_ready,
    output wb_valid, wb_uuid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, wb_eop,
    output retire_valid, retire_cnt
  );
endinterface

// File: rtl/vx_writeback_arb.sv
// Writeback arbiter: round-robin over the execute-unit commit streams that
// write a register, holding a multi-beat response atomic until its eop beat.
// Non-writing commits drain in parallel. The winner is registered onto the
// writeback port one cycle later, along with the retired thread count.
// Optional feature macro: WB_ARB_PERF_EN adds perf_wb_stalls/perf_wb_beats.
module vx_writeback_arb #(
  parameter int NUM_REQS    = 5,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 5,
  parameter int PC_W        = 32,
  parameter int DATA_W      = 32,
  parameter int UUID_W      = 44
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_writeback_arb_if.slave    bus
`ifdef WB_ARB_PERF_EN
  ,
  output logic [43:0]          perf_wb_stalls,
  output logic [43:0]          perf_wb_beats
`endif
);
  localparam int IDX_W  = $clog2(NUM_REQS);
  localparam int RCNT_W = $clog2(NUM_REQS * NUM_THREADS + 1);
  localparam int BEAT_W = NUM_THREADS * DATA_W;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [IDX_W-1:0]       lock_idx_q, lock_idx_d;

  logic [NUM_REQS-1:0]    wb_req;
  logic [NUM_REQS-1:0]    in_ready_w;
  logic [NUM_REQS-1:0]    fire;
  logic [IDX_W-1:0]       grant;
  logic [IDX_W-1:0]       cand;
  logic                   grant_valid;
  logic [RCNT_W-1:0]      retire_sum;

  logic                   wb_valid_q;
  logic [UUID_W-1:0]      wb_uuid_q;
  logic [NW_BITS-1:0]     wb_wid_q;
  logic [NUM_THREADS-1:0] wb_tmask_q;
  logic [PC_W-1:0]        wb_pc_q;
  logic [NR_BITS-1:0]     wb_rd_q;
  logic [BEAT_W-1:0]      wb_data_q;
  logic                   wb_eop_q;
  logic                   retire_valid_q;
  logic [RCNT_W-1:0]      retire_cnt_q;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_REQS - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign wb_req = bus.in_valid & bus.in_wb;

  // Grant selection and ready: ready depends only on valid/wb/state, never on wb_*
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    grant       = '0;
    grant_valid = 1'b0;
    cand        = '0;
    if (state_q == ST_LOCKED) begin
      grant       = lock_idx_q;
      grant_valid = wb_req[lock_idx_q];
    end else begin
      for (int k = 0; k < NUM_REQS; k++) begin
        cand = IDX_W'((int'(rr_q) + k) % NUM_REQS);
        if (!grant_valid && wb_req[cand]) begin
          grant       = cand;
          grant_valid = 1'b1;
        end
      end
    end
    in_ready_w = ~bus.in_wb;
    if (grant_valid) in_ready_w[grant] = 1'b1;
  end

  assign bus.in_ready = in_ready_w;
  assign fire         = bus.in_valid & in_ready_w;

  // Arbiter next state: rr advances past the winner; a non-eop beat locks on it
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    lock_idx_d = lock_idx_q;
    if (grant_valid) begin
      if (state_q == ST_IDLE) begin
        rr_d = wrap_inc(grant);
        if (!bus.in_eop[grant]) begin
          state_d    = ST_LOCKED;
          lock_idx_d = grant;
        end
      end else if (bus.in_eop[grant]) begin
        state_d = ST_IDLE;
        rr_d    = wrap_inc(lock_idx_q);
      end
    end
  end

  // Retired thread-instructions: active lanes of every eop beat consumed this cycle
  always_comb begin
    retire_sum = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (fire[k] && bus.in_eop[k]) begin
        retire_sum = retire_sum
                   + RCNT_W'($countones(bus.in_tmask[k*NUM_THREADS +: NUM_THREADS]));
      end
    end
  end

  // Arbiter state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Writeback and retire output registers; fields hold when nothing is granted
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q     <= 1'b0;
      wb_uuid_q      <= '0;
      wb_wid_q       <= '0;
      wb_tmask_q     <= '0;
      wb_pc_q        <= '0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      wb_eop_q       <= 1'b0;
      retire_valid_q <= 1'b0;
      retire_cnt_q   <= '0;
    end else begin
      wb_valid_q     <= grant_valid;
      retire_cnt_q   <= retire_sum;
      retire_valid_q <= (retire_sum != '0);
      if (grant_valid) begin
        wb_uuid_q  <= bus.in_uuid[int'(grant)*UUID_W +: UUID_W];
        wb_wid_q   <= bus.in_wid[int'(grant)*NW_BITS +: NW_BITS];
        wb_tmask_q <= bus.in_tmask[int'(grant)*NUM_THREADS +: NUM_THREADS];
        wb_pc_q    <= bus.in_PC[int'(grant)*PC_W +: PC_W];
        wb_rd_q    <= bus.in_rd[int'(grant)*NR_BITS +: NR_BITS];
        wb_data_q  <= bus.in_data[int'(grant)*BEAT_W +: BEAT_W];
        wb_eop_q   <= bus.in_eop[grant];
      end
    end
  end

  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_uuid      = wb_uuid_q;
  assign bus.wb_wid       = wb_wid_q;
  assign bus.wb_tmask     = wb_tmask_q;
  assign bus.wb_PC        = wb_pc_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_eop       = wb_eop_q;
  assign bus.retire_valid = retire_valid_q;
  assign bus.retire_cnt   = retire_cnt_q;

`ifdef WB_ARB_PERF_EN
  logic [43:0] perf_stalls_q;
  logic [43:0] perf_beats_q;

  // Perf counters: cycles with a held writing requestor, and writeback beats
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls_q <= '0;
      perf_beats_q  <= '0;
    end else begin
      if (|(wb_req & ~in_ready_w)) perf_stalls_q <= perf_stalls_q + 44'd1;
      if (grant_valid)             perf_beats_q  <= perf_beats_q + 44'd1;
    end
  end

  assign perf_wb_stalls = perf_stalls_q;
  assign perf_wb_beats  = perf_beats_q;
`endif
endmodule

// File: tb/tb_vx_writeback_arb.sv
// Self-checking bench for vx_writeback_arb. Test tasks drive per-unit commit
// beats, check in_ready inline and push the expected writeback/retire result;
// a negedge monitor pops and compares once the registered outputs appear.
module tb_vx_writeback_arb;
  localparam int NR  = 5;
  localparam int NT  = 4;
  localparam int NWB = 2;
  localparam int NRB = 5;
  localparam int PCW = 32;
  localparam int DW  = 32;
  localparam int UW  = 44;
  localparam int RCW = $clog2(NR * NT + 1);

  typedef struct packed {
    logic [UW-1:0]    uuid;
    logic [NWB-1:0]   wid;
    logic [NT-1:0]    tmask;
    logic [PCW-1:0]   pc;
    logic [NRB-1:0]   rd;
    logic [NT*DW-1:0] data;
    logic             eop;
  } beat_t;

  typedef struct {
    logic          valid;
    beat_t         beat;
    logic [RCW-1:0] retire;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_writeback_arb_if #(
    .NUM_REQS(NR), .NUM_THREADS(NT), .NW_BITS(NWB), .NR_BITS(NRB),
    .PC_W(PCW), .DATA_W(DW), .UUID_W(UW)
  ) bus ();

`ifdef WB_ARB_PERF_EN
  logic [43:0] perf_stalls;
  logic [43:0] perf_beats;
`endif

  vx_writeback_arb #(
    .NUM_REQS(NR), .NUM_THREADS(NT), .NW_BITS(NWB), .NR_BITS(NRB),
    .PC_W(PCW), .DATA_W(DW), .UUID_W(UW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_wb_stalls (perf_stalls),
    .perf_wb_beats  (perf_beats)
`endif
  );

  logic [NR-1:0] drv_valid;
  logic [NR-1:0] drv_wb;
  beat_t         drv_beat [NR];

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  // Flatten the per-unit stimulus onto the interface
  always_comb begin
    bus.in_valid = drv_valid;
    bus.in_wb    = drv_wb;
    for (int k = 0; k < NR; k++) begin
      bus.in_uuid[k*UW +: UW]        = drv_beat[k].uuid;
      bus.in_wid[k*NWB +: NWB]       = drv_beat[k].wid;
      bus.in_tmask[k*NT +: NT]       = drv_beat[k].tmask;
      bus.in_PC[k*PCW +: PCW]        = drv_beat[k].pc;
      bus.in_rd[k*NRB +: NRB]        = drv_beat[k].rd;
      bus.in_data[k*NT*DW +: NT*DW]  = drv_beat[k].data;
      bus.in_eop[k]                  = drv_beat[k].eop;
    end
  end

  function automatic beat_t mk(input int unit, input int seq, input logic eop,
                               input logic [NT-1:0] tm);
    beat_t b;
    b.uuid  = UW'(unit * 4096 + seq);
    b.wid   = NWB'(unit);
    b.tmask = tm;
    b.pc    = 32'h8000_0000 + 32'(unit * 256 + seq * 4);
    b.rd    = NRB'(unit * 5 + seq);
    for (int t = 0; t < NT; t++) b.data[t*DW +: DW] = 32'((unit << 24) | (seq << 8) | t);
    b.eop   = eop;
    return b;
  endfunction

  task automatic drive(input int unit, input logic v, input logic wb, input beat_t b);
    drv_valid[unit] = v;
    drv_wb[unit]    = wb;
    drv_beat[unit]  = b;
  endtask

  task automatic idle_all();
    drv_valid = '0;
    drv_wb    = '0;
    for (int k = 0; k < NR; k++) drv_beat[k] = '0;
  endtask

  task automatic push_exp(input logic v, input beat_t b, input int retire);
    exp_t e;
    e.valid  = v;
    e.beat   = b;
    e.retire = RCW'(retire);
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: outputs of the previous cycle, sampled mid-cycle
  always @(negedge clk) begin : monitor
    exp_t  e;
    beat_t got;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = {bus.wb_uuid, bus.wb_wid, bus.wb_tmask, bus.wb_PC, bus.wb_rd, bus.wb_data, bus.wb_eop};
      checks++;
      if (bus.wb_valid !== e.valid) begin
        errors++;
        $display("FAIL wb_valid @%0t: got %b want %b", $time, bus.wb_valid, e.valid);
      end
      if (e.valid) begin
        checks++;
        if (got !== e.beat) begin
          errors++;
          $display("FAIL wb_beat @%0t: got uuid=%0h rd=%0d eop=%b data=%h want uuid=%0h rd=%0d eop=%b data=%h",
                   $time, got.uuid, got.rd, got.eop, got.data,
                   e.beat.uuid, e.beat.rd, e.beat.eop, e.beat.data);
        end
      end
      checks++;
      if (bus.retire_cnt !== e.retire) begin
        errors++;
        $display("FAIL retire_cnt @%0t: got %0d want %0d", $time, bus.retire_cnt, e.retire);
      end
      checks++;
      if (bus.retire_valid !== (e.retire != 0)) begin
        errors++;
        $display("FAIL retire_valid @%0t: got %b want %b", $time, bus.retire_valid, e.retire != 0);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    idle_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", bus.wb_valid); end
    checks++;
    if (bus.retire_valid !== 1'b0 || bus.retire_cnt !== '0) begin
      errors++; $display("FAIL reset_retire: got v=%b cnt=%0d want v=0 cnt=0", bus.retire_valid, bus.retire_cnt);
    end
    checks++;
    if (bus.in_ready !== 5'b11111) begin errors++; $display("FAIL reset_ready: got %b want 11111", bus.in_ready); end
    checks++;
    if ({bus.wb_uuid, bus.wb_PC, bus.wb_rd, bus.wb_data, bus.wb_tmask} !== '0) begin
      errors++; $display("FAIL reset_fields: got uuid=%0h pc=%0h want 0", bus.wb_uuid, bus.wb_PC);
    end
    reset  = 1'b0;
    drv_wb = 5'b10101;
    #1;
    checks++;
    if (bus.in_ready !== 5'b01010) begin errors++; $display("FAIL idle_ready: got %b want 01010", bus.in_ready); end
    @(negedge clk);
    checks++;
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL idle_wb_valid: got %b want 0", bus.wb_valid); end
    idle_all();
  endtask

  // ALU and LSU single-beat every cycle: grants alternate 0,1,0,1,...
  task automatic test_alternate(input int cycles);
    beat_t b0, b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk); #2;
      b0 = mk(0, c, 1'b1, 4'b1111);
      b1 = mk(1, c, 1'b1, 4'b0101);
      drive(0, 1'b1, 1'b1, b0);
      drive(1, 1'b1, 1'b1, b1);
      #1;
      checks++;
      if (bus.in_ready !== ((c % 2 == 0) ? 5'b11101 : 5'b11110)) begin
        errors++; $display("FAIL alt_ready c=%0d: got %b want %b", c, bus.in_ready,
                           (c % 2 == 0) ? 5'b11101 : 5'b11110);
      end
      if (c % 2 == 0) push_exp(1'b1, b0, 4);
      else            push_exp(1'b1, b1, 2);
    end
    @(negedge clk); #2;
    idle_all();
    push_exp(1'b0, '0, 0);
  endtask

  // LSU 3-beat packet with ALU waiting: LSU,LSU,LSU then ALU (rr at 2 on entry)
  task automatic test_lock();
    beat_t bl, ba;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #2;
      bl = mk(1, 10 + c, (c == 2), 4'b0011);
      ba = mk(0, 10 + c, 1'b1, 4'b0111);
      drive(1, (c < 3), 1'b1, bl);
      drive(0, (c > 0), 1'b1, ba);
      #1;
      checks++;
      if (bus.in_ready !== ((c < 3) ? 5'b11110 : 5'b11101)) begin
        errors++; $display("FAIL lock_ready c=%0d: got %b want %b", c, bus.in_ready,
                           (c < 3) ? 5'b11110 : 5'b11101);
      end
      if (c < 3) push_exp(1'b1, bl, (c == 2) ? 2 : 0);
      else       push_exp(1'b1, ba, 3);
    end
    @(negedge clk); #2;
    idle_all();
    push_exp(1'b0, '0, 0);
  endtask

  // Non-writing CSR drains beside a writing ALU; retire counts both
  task automatic test_parallel();
    beat_t ba, bc;
    @(negedge clk); #2;
    ba = mk(0, 20, 1'b1, 4'b1111);
    bc = mk(2, 20, 1'b1, 4'b1011);
    drive(0, 1'b1, 1'b1, ba);
    drive(2, 1'b1, 1'b0, bc);
    #1;
    checks++;
    if (bus.in_ready !== 5'b11111) begin errors++; $display("FAIL par_ready: got %b want 11111", bus.in_ready); end
    push_exp(1'b1, ba, 7);
    @(negedge clk); #2;
    drive(0, 1'b0, 1'b0, '0);
    bc = mk(2, 21, 1'b0, 4'b1011);
    drive(2, 1'b1, 1'b0, bc);
    #1;
    checks++;
    if (bus.in_ready !== 5'b11111) begin errors++; $display("FAIL par_noeop_ready: got %b want 11111", bus.in_ready); end
    push_exp(1'b0, '0, 0);
    @(negedge clk); #2;
    idle_all();
    push_exp(1'b0, '0, 0);
  endtask

  // LSU locked, goes invalid for 2 cycles; FPU must be held until LSU eop fires
  task automatic test_lock_hold();
    beat_t bl, bf;
    logic [4:0] want;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #2;
      bl = mk(1, 30 + c, (c == 3), 4'b1100);
      bf = mk(3, 30 + c, 1'b1, 4'b1110);
      drive(1, (c == 0 || c == 3), 1'b1, bl);
      drive(3, (c > 0), 1'b1, bf);
      #1;
      case (c)
        0, 3:    want = 5'b10111;
        1, 2:    want = 5'b10101;
        default: want = 5'b11101;
      endcase
      checks++;
      if (bus.in_ready !== want) begin
        errors++; $display("FAIL hold_ready c=%0d: got %b want %b", c, bus.in_ready, want);
      end
      case (c)
        0:       push_exp(1'b1, bl, 0);
        3:       push_exp(1'b1, bl, 2);
        4:       push_exp(1'b1, bf, 3);
        default: push_exp(1'b0, '0, 0);
      endcase
    end
    @(negedge clk); #2;
    idle_all();
    push_exp(1'b0, '0, 0);
  endtask

  // Reset while LSU holds the lock: lock dropped, ALU wins right after
  task automatic test_reset_mid_lock();
    beat_t bl, ba;
    @(negedge clk); #2;
    bl = mk(1, 40, 1'b0, 4'b1111);
    drive(1, 1'b1, 1'b1, bl);
    #1;
    checks++;
    if (bus.in_ready !== 5'b11111) begin errors++; $display("FAIL rml_ready0: got %b want 11111", bus.in_ready); end
    push_exp(1'b1, bl, 0);
    @(negedge clk); #2;
    reset = 1'b1;
    drive(1, 1'b1, 1'b1, mk(1, 41, 1'b0, 4'b1111));
    drive(0, 1'b1, 1'b1, mk(0, 41, 1'b1, 4'b0001));
    push_exp(1'b0, '0, 0);
    @(negedge clk); #2;
    reset = 1'b0;
    ba = mk(0, 42, 1'b1, 4'b0001);
    drive(1, 1'b0, 1'b1, '0);
    drive(0, 1'b1, 1'b1, ba);
    #1;
    checks++;
    if (bus.in_ready !== 5'b11101) begin errors++; $display("FAIL rml_ready2: got %b want 11101", bus.in_ready); end
    push_exp(1'b1, ba, 1);
    @(negedge clk); #2;
    idle_all();
    push_exp(1'b0, '0, 0);
  endtask

`ifdef WB_ARB_PERF_EN
  task automatic test_perf();
    @(negedge clk); #2;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    test_alternate(10);
    @(negedge clk); #1;
    checks++;
    if (perf_beats !== 44'd10) begin errors++; $display("FAIL perf_beats: got %0d want 10", perf_beats); end
    checks++;
    if (perf_stalls !== 44'd10) begin errors++; $display("FAIL perf_stalls: got %0d want 10", perf_stalls); end
  endtask
`endif

  initial begin
    test_reset();
    test_alternate(6);
    test_lock();
    test_parallel();
    test_lock_hold();
    test_reset_mid_lock();
`ifdef WB_ARB_PERF_EN
    test_perf();
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout want completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
